// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_LDR  = 1'b1;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned CNT_W      = 3;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-requester round-robin picker: on a tie the port that did not win last time is chosen.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req_core,
  input  logic req_ldr,
  input  logic last_grant,
  output logic gnt
);

  always_comb begin
    gnt = GNT_CORE;
    if (req_core && req_ldr) begin
      gnt = (last_grant == GNT_CORE) ? GNT_LDR : GNT_CORE;
    end else if (req_ldr) begin
      gnt = GNT_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer/arbiter for the single-port unified RAM shared by the core and a loader port.
// The loader port is only functional when MEM_ARB_LOADER_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ready,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_rd_lat_chk
    $error("mem_port_arbiter: RD_LAT=%0d outside supported range", RD_LAT);
  end

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              req_we_q, req_we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              core_ready_q, core_ready_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;

  logic              any_req_c;
  logic              pick_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

`ifdef MEM_ARB_LOADER_EN
  logic              last_grant_q, last_grant_d;
  logic              ldr_ready_q, ldr_ready_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  mem_arb_rr2 u_rr2 (
    .req_core   (core_req),
    .req_ldr    (ldr_req),
    .last_grant (last_grant_q),
    .gnt        (pick_c)
  );

  assign any_req_c   = core_req | ldr_req;
  assign sel_we_c    = (pick_c == GNT_LDR) ? ldr_we    : core_we;
  assign sel_addr_c  = (pick_c == GNT_LDR) ? ldr_addr  : core_addr;
  assign sel_wdata_c = (pick_c == GNT_LDR) ? ldr_wdata : core_wdata;

  assign ldr_ready = ldr_ready_q;
  assign ldr_rdata = ldr_rdata_q;
`else
  // Loader inputs are intentionally ignored in this build.
  logic unused_ldr;
  assign unused_ldr = ^{ldr_req, ldr_we, ldr_addr, ldr_wdata};

  assign pick_c      = GNT_CORE;
  assign any_req_c   = core_req;
  assign sel_we_c    = core_we;
  assign sel_addr_c  = core_addr;
  assign sel_wdata_c = core_wdata;

  assign ldr_ready = 1'b0;
  assign ldr_rdata = '0;
`endif

  assign core_ready = core_ready_q;
  assign core_rdata = core_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Next-state and registered-output logic; outputs are set one cycle ahead of their state.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    req_we_d     = req_we_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_ready_d = 1'b0;
    core_rdata_d = core_rdata_q;
`ifdef MEM_ARB_LOADER_EN
    last_grant_d = last_grant_q;
    ldr_ready_d  = 1'b0;
    ldr_rdata_d  = ldr_rdata_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (any_req_c) begin
          gnt_d       = pick_c;
          req_we_d    = sel_we_c;
          mem_addr_d  = sel_addr_c;
          mem_wdata_d = sel_wdata_c;
          mem_en_d    = 1'b1;
          mem_we_d    = sel_we_c;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (req_we_q) begin
          core_ready_d = (gnt_q == GNT_CORE);
`ifdef MEM_ARB_LOADER_EN
          ldr_ready_d  = (gnt_q == GNT_LDR);
`endif
          state_d      = RESP;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (gnt_q == GNT_CORE) core_rdata_d = mem_rdata;
`ifdef MEM_ARB_LOADER_EN
          if (gnt_q == GNT_LDR) ldr_rdata_d = mem_rdata;
          ldr_ready_d  = (gnt_q == GNT_LDR);
`endif
          core_ready_d = (gnt_q == GNT_CORE);
          state_d      = RESP;
        end
      end
      RESP: begin
`ifdef MEM_ARB_LOADER_EN
        last_grant_d = gnt_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_CORE;
      req_we_q     <= 1'b0;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_ready_q <= 1'b0;
      core_rdata_q <= '0;
`ifdef MEM_ARB_LOADER_EN
      last_grant_q <= GNT_LDR;
      ldr_ready_q  <= 1'b0;
      ldr_rdata_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      req_we_q     <= req_we_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_ready_q <= core_ready_d;
      core_rdata_q <= core_rdata_d;
`ifdef MEM_ARB_LOADER_EN
      last_grant_q <= last_grant_d;
      ldr_ready_q  <= ldr_ready_d;
      ldr_rdata_q  <= ldr_rdata_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // RD_LAT=1 instance
  logic        c1_req = 1'b0, c1_we = 1'b0;
  logic [31:0] c1_addr = '0, c1_wdata = '0;
  logic [31:0] c1_rdata;
  logic        c1_ready;
  logic        l1_req = 1'b0, l1_we = 1'b0;
  logic [31:0] l1_addr = '0, l1_wdata = '0;
  logic [31:0] l1_rdata;
  logic        l1_ready;
  logic        m1_en, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [31:0] m1_rdata = '0;

  // RD_LAT=3 instance, core port only
  logic        c3_req = 1'b0, c3_we = 1'b0;
  logic [31:0] c3_addr = '0, c3_wdata = '0;
  logic [31:0] c3_rdata;
  logic        c3_ready;
  logic [31:0] l3_rdata;
  logic        l3_ready;
  logic        m3_en, m3_we;
  logic [31:0] m3_addr, m3_wdata;
  logic [31:0] m3_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned ldr_pulses = 0;
  int unsigned en3_cnt    = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .core_req(c1_req), .core_we(c1_we), .core_addr(c1_addr), .core_wdata(c1_wdata),
    .core_rdata(c1_rdata), .core_ready(c1_ready),
    .ldr_req(l1_req), .ldr_we(l1_we), .ldr_addr(l1_addr), .ldr_wdata(l1_wdata),
    .ldr_rdata(l1_rdata), .ldr_ready(l1_ready),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .core_req(c3_req), .core_we(c3_we), .core_addr(c3_addr), .core_wdata(c3_wdata),
    .core_rdata(c3_rdata), .core_ready(c3_ready),
    .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0),
    .ldr_rdata(l3_rdata), .ldr_ready(l3_ready),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata)
  );

  always #5 clk = ~clk;

  // Latency-1 RAM with real storage
  logic [31:0] mem1 [0:255];
  always @(posedge clk) begin
    if (m1_en) begin
      if (m1_we) mem1[m1_addr[7:0]] <= m1_wdata;
      else       m1_rdata <= mem1[m1_addr[7:0]];
    end
  end

  // Latency-3 RAM returning an address-derived pattern
  logic [31:0] pipe3 [0:2];
  always @(posedge clk) begin
    pipe3[0] <= (m3_en && !m3_we) ? (m3_addr ^ 32'hA5A5_0000) : 32'h0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign m3_rdata = pipe3[2];

  always @(negedge clk) begin
    if (l1_ready) ldr_pulses <= ldr_pulses + 1;
    if (m3_en)    en3_cnt    <= en3_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issue one core access on the RD_LAT=1 instance and check latency and read data.
  task automatic run_core1(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata);
    int lat = 0;
    c1_req = 1'b1; c1_we = we; c1_addr = addr; c1_wdata = wdata;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (c1_ready) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    if (!we) check({tag, "_rdata"}, c1_rdata, exp_rdata);
    c1_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int unsigned en3_start, p0;
    logic [1:0] who;

    // Reset state
    reset_dut();
    check("rst_mem_en",     m1_en, 1'b0);
    check("rst_mem_we",     m1_we, 1'b0);
    check("rst_mem_addr",   m1_addr, 32'h0);
    check("rst_mem_wdata",  m1_wdata, 32'h0);
    check("rst_core_ready", c1_ready, 1'b0);
    check("rst_ldr_ready",  l1_ready, 1'b0);
    check("rst_core_rdata", c1_rdata, 32'h0);
    check("rst_ldr_rdata",  l1_rdata, 32'h0);
    check("rst3_mem_en",    m3_en, 1'b0);
    check("rst3_mem_wdata", m3_wdata, 32'h0);
    check("rst3_ldr",       {l3_ready, l3_rdata}, 33'h0);

    // Core write 0x10 <- DEADBEEF, cycle by cycle
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 32'h10; c1_wdata = 32'hDEAD_BEEF;
    tick();
    check("wr_c1_en",    m1_en, 1'b1);
    check("wr_c1_we",    m1_we, 1'b1);
    check("wr_c1_addr",  m1_addr, 32'h10);
    check("wr_c1_wdata", m1_wdata, 32'hDEAD_BEEF);
    check("wr_c1_ready", c1_ready, 1'b0);
    tick();
    check("wr_c2_ready", c1_ready, 1'b1);
    check("wr_c2_en",    m1_en, 1'b0);
    c1_req = 1'b0;
    tick();
    check("wr_idle_ready", c1_ready, 1'b0);

    // Core read 0x10; address changes after grant must be ignored
    c1_req = 1'b1; c1_we = 1'b0; c1_wdata = 32'h0;
    tick();
    check("rd_c1_en",   m1_en, 1'b1);
    check("rd_c1_we",   m1_we, 1'b0);
    check("rd_c1_addr", m1_addr, 32'h10);
    c1_addr = 32'h99;
    tick();
    check("rd_c2_ready", c1_ready, 1'b0);
    check("rd_c2_en",    m1_en, 1'b0);
    tick();
    check("rd_c3_ready", c1_ready, 1'b1);
    check("rd_c3_rdata", c1_rdata, 32'hDEAD_BEEF);
    c1_req = 1'b0; c1_addr = 32'h10;
    tick();
    check("rd_idle_ready", c1_ready, 1'b0);
    check("rd_hold_rdata", c1_rdata, 32'hDEAD_BEEF);

    // Further core patterns via the generic task
    run_core1("wr11", 1'b1, 32'h11, 32'h0F0F_0F0F, 2, 32'h0);
    run_core1("rd11", 1'b0, 32'h11, 32'h0,         3, 32'h0F0F_0F0F);
    run_core1("rd10", 1'b0, 32'h10, 32'h0,         3, 32'hDEAD_BEEF);

    // RD_LAT=3 core read: ready 5 cycles after sampling, single mem_en cycle
    en3_start = en3_cnt;
    lat = 0;
    c3_req = 1'b1; c3_we = 1'b0; c3_addr = 32'h20;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (c3_ready) begin
        lat = i;
        break;
      end
    end
    check("lat3_latency", 64'(lat), 64'd5);
    check("lat3_rdata",   c3_rdata, 32'hA5A5_0020);
    check("lat3_en_cnt",  64'(en3_cnt - en3_start), 64'd1);
    c3_req = 1'b0;
    tick();

`ifdef MEM_ARB_LOADER_EN
    // Simultaneous requests after reset: core first, loader after one IDLE cycle
    reset_dut();
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 32'h20; c1_wdata = 32'h1111_2222;
    l1_req = 1'b1; l1_we = 1'b0; l1_addr = 32'h10;
    tick();
    check("arb_c1_addr", m1_addr, 32'h20);
    check("arb_c1_we",   m1_we, 1'b1);
    tick();
    check("arb_c2_core_ready", c1_ready, 1'b1);
    check("arb_c2_ldr_ready",  l1_ready, 1'b0);
    c1_req = 1'b0;
    tick();
    check("arb_c3_ldr_ready", l1_ready, 1'b0);
    check("arb_c3_en",        m1_en, 1'b0);
    tick();
    check("arb_c4_en",   m1_en, 1'b1);
    check("arb_c4_addr", m1_addr, 32'h10);
    check("arb_c4_we",   m1_we, 1'b0);
    tick();
    tick();
    check("arb_c6_ldr_ready", l1_ready, 1'b1);
    check("arb_c6_ldr_rdata", l1_rdata, 32'hDEAD_BEEF);
    l1_req = 1'b0;
    tick();

    // Reset during WAIT of a loader read
    l1_req = 1'b1; l1_we = 1'b0; l1_addr = 32'h11;
    tick();
    check("rw_access_en", m1_en, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    check("rw_en",        m1_en, 1'b0);
    check("rw_ldr_ready", l1_ready, 1'b0);
    check("rw_ldr_rdata", l1_rdata, 32'h0);
    reset = 1'b0; l1_req = 1'b0;
    tick();
    check("rw_ldr_ready2", l1_ready, 1'b0);
    check("rw_en2",        m1_en, 1'b0);

    // Continuous requests from both ports: grants alternate core, loader, ...
    reset_dut();
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 32'h30; c1_wdata = 32'hC0C0_0000;
    l1_req = 1'b1; l1_we = 1'b1; l1_addr = 32'h40; l1_wdata = 32'h1D1D_0000;
    for (int k = 0; k < 4; k++) begin
      who = 2'd0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (c1_ready) begin who = 2'd1; break; end
        if (l1_ready) begin who = 2'd2; break; end
      end
      check($sformatf("rr_grant%0d", k), who, (k % 2 == 0) ? 2'd1 : 2'd2);
      if (who == 2'd1) c1_req = 1'b0;
      else if (who == 2'd2) l1_req = 1'b0;
      tick();
      if (k < 3) begin
        c1_req = 1'b1; l1_req = 1'b1;
      end
    end
    c1_req = 1'b0; l1_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("rr_drain_en", m1_en, 1'b0);
`else
    // Loader held requesting must be ignored; core latency stays nominal
    l1_req = 1'b1; l1_we = 1'b0; l1_addr = 32'h10;
    p0 = ldr_pulses;
    run_core1("nl_wr", 1'b1, 32'h50, 32'h1234_5678, 2, 32'h0);
    run_core1("nl_rd", 1'b0, 32'h50, 32'h0,         3, 32'h1234_5678);
    run_core1("nl_rd2", 1'b0, 32'h10, 32'h0,        3, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) tick();
    check("nl_ldr_pulses", 64'(ldr_pulses - p0), 64'd0);
    check("nl_ldr_rdata",  l1_rdata, 32'h0);
    check("nl_mem_en",     m1_en, 1'b0);
    l1_req = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
